// File: rtl/si_dac_ctrl.sv
// rtl/si_dac_ctrl.sv - sample-rate controller and MSB-first serializer for the 12-bit SI DAC
module si_dac_ctrl #(
    parameter int N      = 12,
    parameter int PERIOD = 32,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [N-1:0]     s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic             SI,
    output logic             SI_en,
    output logic             soc,
    output logic             busy,
    output logic             underrun,
    output logic [CNT_W-1:0] underrun_cnt
);

    localparam int PW = $clog2(PERIOD);
    localparam int BW = (N > 1) ? $clog2(N) : 1;
    localparam logic [PW-1:0] LAST = PW'(PERIOD - 1);

    generate
        if (PERIOD < N + 2) begin : g_bad_period
            $error("si_dac_ctrl: PERIOD must be at least N+2");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, SHIFT, CONV} state_t;

    state_t           state_q;
    logic [PW-1:0]    cnt_q, cnt_d;
    logic [N-1:0]     buf_q, shreg_q;
    logic             buf_full_q;
    logic [BW-1:0]    bit_q;
    logic             si_q, si_en_q, soc_q, busy_q, underrun_q;
    logic [CNT_W-1:0] ur_cnt_q;

    logic tick, load_now, accept;

    assign tick     = enable && (cnt_q == LAST);
    assign load_now = tick && (state_q == IDLE) && buf_full_q;
    assign s_ready  = !buf_full_q || load_now;
    assign accept   = s_valid && s_ready;

    always_comb begin
        cnt_d = cnt_q + PW'(1);
        if (!enable || cnt_q == LAST) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // An accept in the load cycle refills the slot the FSM is emptying.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q      <= '0;
            buf_full_q <= 1'b0;
        end else if (accept) begin
            buf_q      <= s_data;
            buf_full_q <= 1'b1;
        end else if (load_now) begin
            buf_full_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            bit_q      <= '0;
            si_q       <= 1'b0;
            si_en_q    <= 1'b0;
            soc_q      <= 1'b0;
            busy_q     <= 1'b0;
            underrun_q <= 1'b0;
            ur_cnt_q   <= '0;
        end else begin
            underrun_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (tick) begin
                        if (buf_full_q) begin
                            shreg_q <= buf_q;
                            bit_q   <= BW'(N - 1);
                            si_q    <= buf_q[N-1];
                            si_en_q <= 1'b1;
                            busy_q  <= 1'b1;
                            state_q <= SHIFT;
                        end else begin
                            underrun_q <= 1'b1;
                            if (ur_cnt_q != '1) begin
                                ur_cnt_q <= ur_cnt_q + CNT_W'(1);
                            end
                        end
                    end
                end
                SHIFT: begin
                    // si_q is registered, so it is loaded with the bit that becomes the MSB next cycle.
                    shreg_q <= {shreg_q[N-2:0], 1'b0};
                    if (bit_q == '0) begin
                        si_q    <= 1'b0;
                        si_en_q <= 1'b0;
                        soc_q   <= 1'b1;
                        state_q <= CONV;
                    end else begin
                        bit_q <= bit_q - BW'(1);
                        si_q  <= shreg_q[N-2];
                    end
                end
                CONV: begin
                    soc_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign SI           = si_q;
    assign SI_en        = si_en_q;
    assign soc          = soc_q;
    assign busy         = busy_q;
    assign underrun     = underrun_q;
    assign underrun_cnt = ur_cnt_q;

endmodule

// File: tb/tb_si_dac_ctrl.sv
// tb/tb_si_dac_ctrl.sv - scoreboard bench for si_dac_ctrl with a serial DAC capture model
module tb_si_dac_ctrl;

    localparam int N      = 12;
    localparam int PERIOD = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          s_valid = 1'b0;
    logic [N-1:0]  s_data = '0;
    logic          s_ready, SI, SI_en, soc, busy, underrun;
    logic [15:0]   underrun_cnt;
    logic          s_ready2, SI2, SI_en2, soc2, busy2, underrun2;
    logic [1:0]    underrun_cnt2;

    si_dac_ctrl #(.N(N), .PERIOD(PERIOD), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .SI(SI), .SI_en(SI_en), .soc(soc), .busy(busy),
        .underrun(underrun), .underrun_cnt(underrun_cnt)
    );

    si_dac_ctrl #(.N(N), .PERIOD(PERIOD), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready2), .SI(SI2), .SI_en(SI_en2), .soc(soc2), .busy(busy2),
        .underrun(underrun2), .underrun_cnt(underrun_cnt2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [N-1:0] src_q[$];
    logic [N-1:0] exp_q[$];
    logic [N-1:0] got_data[$];
    int           got_bits[$];
    int           got_t[$];
    int           acc_t[$];
    int           frames_total = 0;
    int           en_total = 0;
    int           ur_seen = 0;

    // Source: presents the head of src_q; an accepted sample becomes an expected frame.
    initial begin
        forever begin
            @(negedge clk);
            if (src_q.size() > 0) begin
                s_valid = 1'b1;
                s_data  = src_q[0];
            end else begin
                s_valid = 1'b0;
            end
            #1;
            if (s_valid && s_ready && rst_n) begin
                exp_q.push_back(s_data);
                acc_t.push_back(cyc);
                void'(src_q.pop_front());
            end
        end
    end

    // DAC model: shifts SI while SI_en, latches pdata on soc.
    logic [N-1:0] mon_sr = '0;
    int           nbits = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                nbits = 0;
            end else begin
                if (SI_en) begin
                    mon_sr = {mon_sr[N-2:0], SI};
                    nbits++;
                    en_total++;
                end
                if (soc) begin
                    got_data.push_back(mon_sr);
                    got_bits.push_back(nbits);
                    got_t.push_back(cyc);
                    frames_total++;
                    nbits = 0;
                end
                if (underrun) ur_seen++;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic wait_si_en(output logic ok, output int c);
        ok = 1'b0;
        c  = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (SI_en === 1'b1) begin
                ok = 1'b1;
                c  = cyc;
                break;
            end
        end
    endtask

    task automatic take_frame(output logic ok, output logic [N-1:0] d, output logic [N-1:0] e,
                              output int bits, output int t);
        ok = 1'b0; d = '0; e = 'x; bits = 0; t = 0;
        for (int i = 0; i < 200; i++) begin
            if (got_data.size() > 0) break;
            @(negedge clk);
        end
        if (got_data.size() > 0) begin
            ok   = 1'b1;
            d    = got_data.pop_front();
            bits = got_bits.pop_front();
            t    = got_t.pop_front();
            if (exp_q.size() > 0) e = exp_q.pop_front();
        end
    endtask

    task automatic test_reset;
        rst_n  = 1'b0;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({SI, SI_en, soc, busy, underrun, s_ready} !== 6'b000001)
            $display("FAIL reset_outputs: got %b want 000001", {SI, SI_en, soc, busy, underrun, s_ready});
        else pass_cnt++;
        total_cnt++;
        if (underrun_cnt !== 16'd0)
            $display("FAIL reset_underrun_cnt: got %0d want 0", underrun_cnt);
        else pass_cnt++;
        total_cnt++;
        if ({SI2, SI_en2, soc2, busy2, underrun2, s_ready2, underrun_cnt2} !== 8'b00000100)
            $display("FAIL reset_outputs_cntw2: got %b want 00000100",
                     {SI2, SI_en2, soc2, busy2, underrun2, s_ready2, underrun_cnt2});
        else pass_cnt++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single;
        logic         ok;
        int           c0, c, bits, t;
        logic [N-1:0] d, e;
        logic [N-1:0] pat;
        pat = 12'b1010_0101_1100;
        src_q.push_back(12'hA5C);
        @(negedge clk);
        enable = 1'b1;
        c0 = cyc;
        wait_si_en(ok, c);
        total_cnt++;
        if (!ok || c != c0 + PERIOD)
            $display("FAIL single_first_bit_cycle: got %0d (found=%0b) want %0d", c - c0, ok, PERIOD);
        else pass_cnt++;
        if (ok) begin
            for (int i = 0; i < N; i++) begin
                if (i > 0) @(negedge clk);
                total_cnt++;
                if ({SI_en, SI} !== {1'b1, pat[N-1-i]})
                    $display("FAIL single_bit%0d: got en/si %b want %b", i, {SI_en, SI}, {1'b1, pat[N-1-i]});
                else pass_cnt++;
            end
            @(negedge clk);
            total_cnt++;
            if ({soc, SI_en, SI, busy} !== 4'b1001)
                $display("FAIL single_soc: got soc/en/si/busy %b want 1001", {soc, SI_en, SI, busy});
            else pass_cnt++;
            @(negedge clk);
            total_cnt++;
            if ({soc, busy} !== 2'b00)
                $display("FAIL single_soc_width: got soc/busy %b want 00", {soc, busy});
            else pass_cnt++;
        end
        take_frame(ok, d, e, bits, t);
        enable = 1'b0;
        total_cnt++;
        if (!ok || d !== e || bits != N || t != c0 + PERIOD + N)
            $display("FAIL single_pdata: got %h/%0d bits/soc@%0d want %h/%0d bits/soc@%0d",
                     d, bits, t - c0, e, N, PERIOD + N);
        else pass_cnt++;
    endtask

    task automatic test_stream;
        logic         ok;
        int           bits, t, tprev, ur0;
        logic [N-1:0] d, e;
        ur0 = ur_seen;
        tprev = 0;
        src_q.push_back(12'h000);
        src_q.push_back(12'hFFF);
        src_q.push_back(12'h800);
        src_q.push_back(12'h001);
        @(negedge clk);
        enable = 1'b1;
        for (int k = 0; k < 4; k++) begin
            take_frame(ok, d, e, bits, t);
            total_cnt++;
            if (!ok || d !== e || bits != N)
                $display("FAIL stream_frame%0d: got %h/%0d bits want %h/%0d bits", k, d, bits, e, N);
            else pass_cnt++;
            if (k > 0) begin
                total_cnt++;
                if (t - tprev != PERIOD)
                    $display("FAIL stream_soc_spacing%0d: got %0d want %0d", k, t - tprev, PERIOD);
                else pass_cnt++;
            end
            tprev = t;
        end
        enable = 1'b0;
        total_cnt++;
        if (ur_seen - ur0 != 0)
            $display("FAIL stream_underrun: got %0d pulses want 0", ur_seen - ur0);
        else pass_cnt++;
    endtask

    task automatic test_backpressure;
        logic         ok;
        int           c, bits, t;
        logic [N-1:0] d, e;
        acc_t.delete();
        src_q.push_back(12'h3C3);
        src_q.push_back(12'h5A5);
        src_q.push_back(12'h0F0);
        @(negedge clk);
        enable = 1'b1;
        wait_si_en(ok, c);
        total_cnt++;
        if (!ok || {s_valid, s_ready} !== 2'b10)
            $display("FAIL bp_ready_shift_start: got valid/ready %b (found=%0b) want 10", {s_valid, s_ready}, ok);
        else pass_cnt++;
        repeat (6) @(negedge clk);
        total_cnt++;
        if ({s_valid, s_ready, SI_en} !== 3'b101)
            $display("FAIL bp_ready_shift_mid: got valid/ready/en %b want 101", {s_valid, s_ready, SI_en});
        else pass_cnt++;
        for (int k = 0; k < 3; k++) begin
            take_frame(ok, d, e, bits, t);
            total_cnt++;
            if (!ok || d !== e || bits != N)
                $display("FAIL bp_frame%0d: got %h/%0d bits want %h/%0d bits", k, d, bits, e, N);
            else pass_cnt++;
        end
        enable = 1'b0;
        total_cnt++;
        if (acc_t.size() != 3)
            $display("FAIL bp_accept_count: got %0d want 3", acc_t.size());
        else if (acc_t[1] != c - 1 || acc_t[2] != c - 1 + PERIOD)
            $display("FAIL bp_accept_cycles: got %0d,%0d want %0d,%0d", acc_t[1], acc_t[2], c - 1, c - 1 + PERIOD);
        else pass_cnt++;
        repeat (40) @(negedge clk);
        total_cnt++;
        if (got_data.size() != 0 || exp_q.size() != 0)
            $display("FAIL bp_leftover: got %0d extra frames / %0d missing want 0/0", got_data.size(), exp_q.size());
        else pass_cnt++;
    endtask

    task automatic test_enable_drop;
        logic         ok;
        int           c, c1, bits, t, en0, f0, ur0;
        logic [N-1:0] d, e;
        src_q.push_back(12'h6B1);
        src_q.push_back(12'h29E);
        @(negedge clk);
        enable = 1'b1;
        wait_si_en(ok, c);
        repeat (4) @(negedge clk);
        enable = 1'b0;
        take_frame(ok, d, e, bits, t);
        total_cnt++;
        if (!ok || d !== e || bits != N)
            $display("FAIL endrop_frame: got %h/%0d bits want %h/%0d bits", d, bits, e, N);
        else pass_cnt++;
        en0 = en_total; f0 = frames_total; ur0 = ur_seen;
        repeat (80) @(negedge clk);
        total_cnt++;
        if (en_total != en0 || frames_total != f0 || ur_seen != ur0)
            $display("FAIL endrop_quiet: got en/frames/underruns +%0d/+%0d/+%0d want 0/0/0",
                     en_total - en0, frames_total - f0, ur_seen - ur0);
        else pass_cnt++;
        total_cnt++;
        if ({s_ready, busy} !== 2'b00)
            $display("FAIL endrop_held: got ready/busy %b want 00", {s_ready, busy});
        else pass_cnt++;
        enable = 1'b1;
        c1 = cyc;
        wait_si_en(ok, c);
        total_cnt++;
        if (!ok || c != c1 + PERIOD)
            $display("FAIL endrop_restart_cycle: got %0d (found=%0b) want %0d", c - c1, ok, PERIOD);
        else pass_cnt++;
        take_frame(ok, d, e, bits, t);
        enable = 1'b0;
        total_cnt++;
        if (!ok || d !== e || bits != N)
            $display("FAIL endrop_held_frame: got %h/%0d bits want %h/%0d bits", d, bits, e, N);
        else pass_cnt++;
    endtask

    task automatic test_underrun;
        logic         ok;
        int           bits, t, ur0;
        logic [N-1:0] d, e;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ur0 = ur_seen;
        enable = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (ur_seen - ur0 >= 3) break;
            @(negedge clk);
        end
        total_cnt++;
        if (ur_seen - ur0 != 3 || underrun_cnt !== 16'd3)
            $display("FAIL underrun_three: got pulses %0d cnt %0d want 3/3", ur_seen - ur0, underrun_cnt);
        else pass_cnt++;
        src_q.push_back(12'h123);
        take_frame(ok, d, e, bits, t);
        total_cnt++;
        if (!ok || d !== e || bits != N)
            $display("FAIL underrun_next_frame: got %h/%0d bits want %h/%0d bits", d, bits, e, N);
        else pass_cnt++;
        for (int i = 0; i < 200; i++) begin
            if (ur_seen - ur0 >= 5) break;
            @(negedge clk);
        end
        enable = 1'b0;
        total_cnt++;
        if (underrun_cnt !== 16'd5)
            $display("FAIL underrun_cnt16: got %0d want 5", underrun_cnt);
        else pass_cnt++;
        total_cnt++;
        if (underrun_cnt2 !== 2'd3)
            $display("FAIL underrun_cnt2_saturate: got %0d want 3", underrun_cnt2);
        else pass_cnt++;
    endtask

    task automatic test_reset_midframe;
        logic ok;
        int   c, f0;
        src_q.push_back(12'h7E7);
        @(negedge clk);
        enable = 1'b1;
        wait_si_en(ok, c);
        repeat (6) @(negedge clk);
        f0 = frames_total;
        rst_n  = 1'b0;
        enable = 1'b0;
        #1;
        total_cnt++;
        if ({SI, SI_en, soc, busy, underrun, s_ready} !== 6'b000001 || underrun_cnt !== 16'd0)
            $display("FAIL rst_mid_outputs: got %b cnt %0d want 000001 cnt 0",
                     {SI, SI_en, soc, busy, underrun, s_ready}, underrun_cnt);
        else pass_cnt++;
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        total_cnt++;
        if (frames_total != f0 || got_data.size() != 0 || s_ready !== 1'b1)
            $display("FAIL rst_mid_after: got frames +%0d ready %b want +0 ready 1", frames_total - f0, s_ready);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_enable_drop();
        test_underrun();
        test_reset_midframe();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
